delay_cmd_sched: RTL and testbench
==================================

DELAY_CMD_SCHED -- requirements
Module: delay_cmd_sched

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning cycles a raw key must be stable before it is accepted.
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, meaning held-key cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5000000, meaning the auto-repeat period in cycles.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_faster_n  in  1  raw pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL have port key_slower_n  in  1  raw pushbutton, active-low, asynchronous to clk.
REQ-008 SHALL have port sw_write  in  1  Avalon-style host write strobe, one cycle per write.
REQ-009 SHALL have port sw_writedata  in  8  host write data.
REQ-010 SHALL have port faster  out  1  one-cycle decrement command to the delay register.
REQ-011 SHALL have port slower  out  1  one-cycle increment command to the delay register.
REQ-012 SHALL have port write  out  1  one-cycle load command to the delay register.
REQ-013 SHALL have port writedata  out  8  load value, valid while write=1.
REQ-014 SHALL have port key_busy  out  1  high while either key is in a debounced-pressed state.

Function
REQ-015 SHALL pass each raw key through a 2-flop synchronizer before any other use.
REQ-016 SHALL run a per-key FSM: IDLE -> DEBOUNCE (synced key low) -> HELD (stable low for DEBOUNCE_CYCLES) -> REPEAT (HOLD_CYCLES in HELD) -> REPEAT every REPEAT_CYCLES.
REQ-017 SHALL return a key FSM to DEBOUNCE-release handling on any synced key high, reaching IDLE only after DEBOUNCE_CYCLES stable high; a bounce in DEBOUNCE restarts the count.
REQ-018 SHALL raise one key request on entering HELD and one on each REPEAT period expiry.
REQ-019 SHALL register all outputs; faster, slower and write SHALL be mutually exclusive (at most one high per cycle).
REQ-020 SHALL issue write with writedata=sw_writedata exactly one cycle after sw_write=1 (latency 1), every time, no backpressure.
REQ-021 SHALL give host write priority: a key request coinciding with sw_write, or pending in that cycle, SHALL be discarded.
REQ-022 SHALL issue a key request as faster/slower exactly one cycle after it is raised when no write preempts it.
REQ-023 SHALL discard both requests when faster and slower requests are raised in the same cycle (conflict, no output).
REQ-024 SHALL hold writedata at its last written value when write=0.
REQ-025 SHALL saturate all internal counters at their terminal value; none SHALL wrap.

Reset
REQ-026 SHALL, on reset_n low, immediately force faster=0, slower=0, write=0, writedata=8'h00, key_busy=0, both FSMs to IDLE, counters to 0, synchronizers to 1 (released).
REQ-027 SHALL abandon any in-progress debounce, hold or repeat on reset mid-operation and emit no command in the first cycle after release.

Configuration
REQ-028 SHALL, with DELAY_CMD_SCHED_AUTOREPEAT_EN defined, implement the REPEAT state per REQ-016/REQ-018.
REQ-029 SHALL, without DELAY_CMD_SCHED_AUTOREPEAT_EN, omit REPEAT state and hold/repeat counters; a held key yields exactly one request per press; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Structure
REQ-030 SHALL take key FSM state encodings (IDLE, DEBOUNCE, HELD, REPEAT) and counter width constants from shared package delay_sched_pkg.
REQ-031 SHALL implement synchronizer, debounce and key FSM in sub-module key_debounce, instantiated once per key; arbitration stays in delay_cmd_sched.

Verification
REQ-032 SHALL cover: DEBOUNCE_CYCLES=4, key_faster_n low 10 cycles with 2-cycle bounce at start -> exactly one faster pulse, 5 cycles after last bounce edge.
REQ-033 SHALL cover: sw_write=1, sw_writedata=8'h05 at cycle N -> write=1, writedata=8'h05 at N+1 only.
REQ-034 SHALL cover: key request and sw_write=1, sw_writedata=8'h0C same cycle -> write with 8'h0C, no faster/slower pulse.
REQ-035 SHALL cover: both keys pressed on same cycle -> no command, key_busy=1.
REQ-036 SHALL cover: macro defined, DEBOUNCE=4, HOLD=10, REPEAT=3, key_slower_n held 30 cycles -> slower pulses at press+5, then +10, then every 3 cycles; macro undefined -> single pulse.
REQ-037 SHALL cover: reset_n low mid-REPEAT -> all outputs 0 the same cycle, no pulse for one cycle after release.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared key FSM state encodings, counter width and a saturating increment
// used by the delay command scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    REPEAT   = 2'd3
  } key_state_t;

  localparam int unsigned CNT_W = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key 2-flop synchronizer, press/release debounce and hold/auto-repeat FSM.
// Auto-repeat (REPEAT state) is built only with DELAY_CMD_SCHED_AUTOREPEAT_EN.
import delay_sched_pkg::*;

module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic req,
  output logic busy
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             key_sync;
  key_state_t       state;
  logic             releasing;
  logic [CNT_W-1:0] cnt;
  logic             deb_done;

  assign deb_done = (cnt >= DEB_LAST);

`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] tcnt;
  logic             hold_done;
  logic             rep_done;

  assign hold_done = (tcnt >= HOLD_LAST);
  assign rep_done  = (tcnt >= REP_LAST);
`else
  // Single-shot build: hold/repeat timing parameters have no effect.
  if (HOLD_CYCLES == 0 && REPEAT_CYCLES == 0) begin : g_no_repeat_cfg
  end
`endif

  always_comb begin
    req = 1'b0;
    unique case (state)
      DEBOUNCE: req = !releasing && !key_sync && deb_done;
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
      HELD:     req = !key_sync && hold_done;
      REPEAT:   req = !key_sync && rep_done;
`endif
      default:  req = 1'b0;
    endcase
  end

  assign busy = (state == HELD) || (state == REPEAT) ||
                ((state == DEBOUNCE) && releasing);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      key_sync  <= 1'b1;
      state     <= IDLE;
      releasing <= 1'b0;
      cnt       <= '0;
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
      tcnt      <= '0;
`endif
    end else begin
      sync1    <= key_n;
      key_sync <= sync1;
      unique case (state)
        IDLE: begin
          if (!key_sync) begin
            state     <= DEBOUNCE;
            releasing <= 1'b0;
            cnt       <= CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          // DEBOUNCE serves both press and release; releasing selects which.
          if (!releasing) begin
            if (key_sync) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (deb_done) begin
              state <= HELD;
              cnt   <= '0;
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
              tcnt  <= '0;
`endif
            end else begin
              cnt <= sat_inc(cnt);
            end
          end else begin
            if (!key_sync) begin
              cnt <= '0;
            end else if (deb_done) begin
              state     <= IDLE;
              releasing <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
        end
        HELD: begin
          if (key_sync) begin
            state     <= DEBOUNCE;
            releasing <= 1'b1;
            cnt       <= CNT_W'(1);
          end
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
          else if (hold_done) begin
            state <= REPEAT;
            tcnt  <= '0;
          end else begin
            tcnt <= sat_inc(tcnt);
          end
`endif
        end
        REPEAT: begin
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
          if (key_sync) begin
            state     <= DEBOUNCE;
            releasing <= 1'b1;
            cnt       <= CNT_W'(1);
          end else if (rep_done) begin
            tcnt <= '0;
          end else begin
            tcnt <= sat_inc(tcnt);
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/delay_cmd_sched.sv
// Delay register command scheduler: two debounced keys plus host writes,
// host write wins. Optional auto-repeat via DELAY_CMD_SCHED_AUTOREPEAT_EN.
module delay_cmd_sched #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_faster_n,
  input  logic       key_slower_n,
  input  logic       sw_write,
  input  logic [7:0] sw_writedata,
  output logic       faster,
  output logic       slower,
  output logic       write,
  output logic [7:0] writedata,
  output logic       key_busy
);

  logic req_faster, req_slower;
  logic busy_faster, busy_slower;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_key_faster (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_faster_n),
    .req    (req_faster),
    .busy   (busy_faster)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_key_slower (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_slower_n),
    .req    (req_slower),
    .busy   (busy_slower)
  );

  // Simultaneous key requests cancel each other; a host write drops both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      faster    <= 1'b0;
      slower    <= 1'b0;
      write     <= 1'b0;
      writedata <= '0;
      key_busy  <= 1'b0;
    end else begin
      write    <= sw_write;
      faster   <= req_faster & ~req_slower & ~sw_write;
      slower   <= req_slower & ~req_faster & ~sw_write;
      key_busy <= busy_faster | busy_slower;
      if (sw_write) writedata <= sw_writedata;
    end
  end

endmodule

// File: tb/tb_delay_cmd_sched.sv
// Directed self-checking bench for delay_cmd_sched (DEBOUNCE=4, HOLD=10, REPEAT=3).
module tb_delay_cmd_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_faster_n;
  logic       key_slower_n;
  logic       sw_write;
  logic [7:0] sw_writedata;
  logic       faster;
  logic       slower;
  logic       write;
  logic [7:0] writedata;
  logic       key_busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  delay_cmd_sched #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_faster_n(key_faster_n),
    .key_slower_n(key_slower_n),
    .sw_write    (sw_write),
    .sw_writedata(sw_writedata),
    .faster      (faster),
    .slower      (slower),
    .write       (write),
    .writedata   (writedata),
    .key_busy    (key_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_idle(input string name);
    bit ok;
    ok = 1'b0;
    key_faster_n = 1'b1;
    key_slower_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (faster !== 1'b0 || slower !== 1'b0)
        $display("FAIL %s_release cyc %0d: faster=%b slower=%b, required 0 0", name, i, faster, slower);
      else passed++;
      if (key_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) $display("FAIL %s_idle_timeout: key_busy=%b, required 0 within 30 cycles", name, key_busy);
    else passed++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    key_faster_n = 1'b1;
    key_slower_n = 1'b1;
    sw_write = 1'b0;
    sw_writedata = 8'h00;
    #2;
    checks++;
    if ({faster, slower, write, writedata, key_busy} !== 12'h000)
      $display("FAIL reset_outputs: f=%b s=%b w=%b wd=%h busy=%b, required all 0",
               faster, slower, write, writedata, key_busy);
    else passed++;
    tick();
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({faster, slower, write, writedata, key_busy} !== 12'h000)
        $display("FAIL reset_release cyc %0d: f=%b s=%b w=%b wd=%h busy=%b, required all 0",
                 i, faster, slower, write, writedata, key_busy);
      else passed++;
    end
  endtask

  task automatic test_debounce_bounce;
    key_faster_n = 1'b0;
    tick();
    key_faster_n = 1'b1;
    tick();
    key_faster_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (faster !== (i == 5) || slower !== 1'b0 || write !== 1'b0)
        $display("FAIL debounce_bounce cyc %0d: faster=%b slower=%b write=%b, required faster=%b 0 0",
                 i, faster, slower, write, (i == 5));
      else passed++;
    end
    checks++;
    if (key_busy !== 1'b1) $display("FAIL debounce_busy: key_busy=%b, required 1", key_busy);
    else passed++;
    release_and_idle("debounce");
  endtask

  task automatic test_host_write;
    logic [7:0] data [4];
    data[0] = 8'h05; data[1] = 8'hA3; data[2] = 8'h11; data[3] = 8'h22;
    for (int k = 0; k < 2; k++) begin
      sw_write = 1'b1;
      sw_writedata = data[k];
      tick();
      sw_write = 1'b0;
      sw_writedata = 8'hFF;
      checks++;
      if (write !== 1'b1 || writedata !== data[k] || faster !== 1'b0 || slower !== 1'b0)
        $display("FAIL host_write %0d: write=%b wd=%h, required 1 %h", k, write, writedata, data[k]);
      else passed++;
      for (int i = 0; i < 2; i++) begin
        tick();
        checks++;
        if (write !== 1'b0 || writedata !== data[k])
          $display("FAIL host_write_hold %0d.%0d: write=%b wd=%h, required 0 %h", k, i, write, writedata, data[k]);
        else passed++;
      end
    end
    sw_write = 1'b1;
    sw_writedata = data[2];
    tick();
    sw_writedata = data[3];
    checks++;
    if (write !== 1'b1 || writedata !== data[2])
      $display("FAIL back_to_back_0: write=%b wd=%h, required 1 %h", write, writedata, data[2]);
    else passed++;
    tick();
    sw_write = 1'b0;
    checks++;
    if (write !== 1'b1 || writedata !== data[3])
      $display("FAIL back_to_back_1: write=%b wd=%h, required 1 %h", write, writedata, data[3]);
    else passed++;
    tick();
    checks++;
    if (write !== 1'b0 || writedata !== data[3])
      $display("FAIL back_to_back_end: write=%b wd=%h, required 0 %h", write, writedata, data[3]);
    else passed++;
  endtask

  task automatic test_write_priority;
    key_faster_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (i == 5) begin
        if (write !== 1'b1 || writedata !== 8'h0C || faster !== 1'b0 || slower !== 1'b0)
          $display("FAIL write_priority: write=%b wd=%h faster=%b slower=%b, required 1 0c 0 0",
                   write, writedata, faster, slower);
        else passed++;
      end else begin
        if (write !== 1'b0 || faster !== 1'b0 || slower !== 1'b0)
          $display("FAIL write_priority cyc %0d: write=%b faster=%b slower=%b, required 0 0 0",
                   i, write, faster, slower);
        else passed++;
      end
      if (i == 4) begin
        sw_write = 1'b1;
        sw_writedata = 8'h0C;
      end else begin
        sw_write = 1'b0;
      end
    end
    release_and_idle("write_priority");
  endtask

  task automatic test_conflict;
    key_faster_n = 1'b0;
    key_slower_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (faster !== 1'b0 || slower !== 1'b0 || write !== 1'b0)
        $display("FAIL conflict cyc %0d: faster=%b slower=%b write=%b, required 0 0 0",
                 i, faster, slower, write);
      else passed++;
      if (i >= 6) begin
        checks++;
        if (key_busy !== 1'b1) $display("FAIL conflict_busy cyc %0d: key_busy=%b, required 1", i, key_busy);
        else passed++;
      end
    end
    release_and_idle("conflict");
  endtask

  task automatic test_autorepeat;
    bit exp;
    key_slower_n = 1'b0;
    for (int i = 0; i < 46; i++) begin
      tick();
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
      exp = (i == 5) || (i == 15) || (i >= 18 && i <= 30 && ((i - 18) % 3) == 0);
`else
      exp = (i == 5);
`endif
      checks++;
      if (slower !== exp || faster !== 1'b0)
        $display("FAIL autorepeat cyc %0d: slower=%b faster=%b, required %b 0", i, slower, faster, exp);
      else passed++;
      if (i == 29) key_slower_n = 1'b1;
    end
    checks++;
    if (key_busy !== 1'b0) $display("FAIL autorepeat_idle: key_busy=%b, required 0", key_busy);
    else passed++;
  endtask

  task automatic test_reset_mid;
    key_slower_n = 1'b0;
    for (int i = 0; i < 19; i++) tick();
`ifdef DELAY_CMD_SCHED_AUTOREPEAT_EN
    checks++;
    if (slower !== 1'b1) $display("FAIL reset_mid_pre_pulse: slower=%b, required 1", slower);
    else passed++;
`endif
    checks++;
    if (key_busy !== 1'b1) $display("FAIL reset_mid_pre_busy: key_busy=%b, required 1", key_busy);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({faster, slower, write, writedata, key_busy} !== 12'h000)
      $display("FAIL reset_mid_async: f=%b s=%b w=%b wd=%h busy=%b, required all 0",
               faster, slower, write, writedata, key_busy);
    else passed++;
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (slower !== (i == 5) || faster !== 1'b0 || write !== 1'b0)
        $display("FAIL reset_mid_after cyc %0d: slower=%b faster=%b write=%b, required %b 0 0",
                 i, slower, faster, write, (i == 5));
      else passed++;
    end
    release_and_idle("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce_bounce();
    test_host_write();
    test_write_priority();
    test_conflict();
    test_autorepeat();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
